// File: rtl/dot_scoreboard_if.sv
// Signal bundle between the dot bitmap owner / game-state FSM and the dot scoreboard.
interface dot_scoreboard_if #(
  parameter int NT      = 768,
  parameter int CNT_W   = $clog2(NT + 1),
  parameter int SCORE_W = 16
);
  logic [NT-1:0]      tilemap_dots;
  logic               start;
  logic               score_clear;
  logic [CNT_W-1:0]   dots_remaining;
  logic               dots_valid;
  logic [SCORE_W-1:0] score;
  logic               sweep_done;
  logic               level_clear;
  logic               busy;

  modport master (
    output tilemap_dots, start, score_clear,
    input  dots_remaining, dots_valid, score, sweep_done, level_clear, busy
  );

  modport slave (
    input  tilemap_dots, start, score_clear,
    output dots_remaining, dots_valid, score, sweep_done, level_clear, busy
  );
endinterface

// File: rtl/dot_scoreboard.sv
// Sweeps the shared dot bitmap chunk by chunk, tracks remaining dots, converts
// sweep-to-sweep decreases into saturating score and flags level clear.
module dot_scoreboard #(
  parameter int ROWS           = 24,
  parameter int COLS           = 32,
  parameter int SCAN_W         = 8,
  parameter int POINTS_PER_DOT = 10,
  parameter int SCORE_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  dot_scoreboard_if.slave  bus
);
  localparam int NT     = ROWS * COLS;
  localparam int NCHUNK = NT / SCAN_W;
  localparam int CNT_W  = $clog2(NT + 1);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int POP_W  = $clog2(SCAN_W + 1);
  localparam int SUM_W  = SCORE_W + CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INIT    = 2'd1,
    ST_RUN     = 2'd2,
    ST_CLEARED = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   acc_r;
  logic [CNT_W-1:0]   dots_remaining_r;
  logic               dots_valid_r;
  logic [SCORE_W-1:0] score_r;
  logic               sweep_done_r;
  logic               level_clear_r;

  logic [SCAN_W-1:0]  chunk_s;
  logic [CNT_W-1:0]   total_s;
  logic               last_s;
  logic               scanning_s;
  logic               sweep_end_s;
  logic [SUM_W-1:0]   sum_s;
  logic [SCORE_W-1:0] score_sat_s;
  logic               score_add_s;
  logic               busy_s;

  function automatic logic [POP_W-1:0] popcount(input logic [SCAN_W-1:0] v);
    logic [POP_W-1:0] n;
    n = {POP_W{1'b0}};
    for (int i = 0; i < SCAN_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  // Chunk count, sweep-end detection and saturating score arithmetic
  always_comb begin
    chunk_s     = bus.tilemap_dots[int'(idx_r) * SCAN_W +: SCAN_W];
    total_s     = acc_r + CNT_W'(popcount(chunk_s));
    last_s      = (idx_r == IDX_W'(NCHUNK - 1));
    scanning_s  = (state_r == ST_INIT) || (state_r == ST_RUN);
    sweep_end_s = scanning_s && last_s && !bus.start;
    sum_s       = SUM_W'(score_r)
                + SUM_W'(dots_remaining_r - total_s) * SUM_W'(POINTS_PER_DOT);
    if (sum_s > SUM_W'({SCORE_W{1'b1}})) begin
      score_sat_s = {SCORE_W{1'b1}};
    end else begin
      score_sat_s = sum_s[SCORE_W-1:0];
    end
    // Only a genuine decrease during RUN scores; restored dots are ignored
    score_add_s = sweep_end_s && (state_r == ST_RUN) && (total_s < dots_remaining_r);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; start restarts counting from any state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_next_s = ST_INIT;
        else           state_next_s = ST_IDLE;
      end
      ST_INIT, ST_RUN: begin
        if (bus.start)               state_next_s = ST_INIT;
        else if (!last_s)            state_next_s = state_r;
        else if (total_s == '0)      state_next_s = ST_CLEARED;
        else                         state_next_s = ST_RUN;
      end
      ST_CLEARED: begin
        if (bus.start) state_next_s = ST_INIT;
        else           state_next_s = ST_CLEARED;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      ST_INIT, ST_RUN: busy_s = 1'b1;
      default:         busy_s = 1'b0;
    endcase
  end

  // Scan datapath, sweep results and score register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r            <= {IDX_W{1'b0}};
      acc_r            <= {CNT_W{1'b0}};
      dots_remaining_r <= {CNT_W{1'b0}};
      dots_valid_r     <= 1'b0;
      score_r          <= {SCORE_W{1'b0}};
      sweep_done_r     <= 1'b0;
      level_clear_r    <= 1'b0;
    end else begin
      sweep_done_r <= 1'b0;
      if (bus.score_clear) begin
        score_r <= {SCORE_W{1'b0}};
      end else if (score_add_s) begin
        score_r <= score_sat_s;
      end
      if (bus.start) begin
        idx_r         <= {IDX_W{1'b0}};
        acc_r         <= {CNT_W{1'b0}};
        level_clear_r <= 1'b0;
        dots_valid_r  <= 1'b0;
      end else if (scanning_s) begin
        if (last_s) begin
          idx_r            <= {IDX_W{1'b0}};
          acc_r            <= {CNT_W{1'b0}};
          dots_remaining_r <= total_s;
          dots_valid_r     <= 1'b1;
          sweep_done_r     <= 1'b1;
          if (total_s == {CNT_W{1'b0}}) level_clear_r <= 1'b1;
        end else begin
          idx_r <= idx_r + IDX_W'(1);
          acc_r <= total_s;
        end
      end
    end
  end

  assign bus.dots_remaining = dots_remaining_r;
  assign bus.dots_valid     = dots_valid_r;
  assign bus.score          = score_r;
  assign bus.sweep_done     = sweep_done_r;
  assign bus.level_clear    = level_clear_r;
  assign bus.busy           = busy_s;
endmodule

// File: tb/tb_dot_scoreboard.sv
// Directed bench for dot_scoreboard: a default instance plus an 8-bit score instance.
module tb_dot_scoreboard;
  logic clk;
  logic reset;
  int   tests;
  int   failed;

  dot_scoreboard_if #(.NT(768), .SCORE_W(16)) bus16 ();
  dot_scoreboard_if #(.NT(768), .SCORE_W(8))  bus8 ();

  dot_scoreboard #(.SCORE_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  dot_scoreboard #(.SCORE_W(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n dots spread over the map at every 12th tile; fewer n clears the highest ones
  function automatic logic [767:0] pattern(input int n);
    logic [767:0] p;
    p = '0;
    for (int i = 0; i < n; i++) p[i * 12] = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick_n(3);
    tests++; if (bus16.dots_remaining !== 10'd0) begin failed++; $display("FAIL reset_dots got %0d exp 0", bus16.dots_remaining); end
    tests++; if (bus16.dots_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", bus16.dots_valid); end
    tests++; if (bus16.score !== 16'd0) begin failed++; $display("FAIL reset_score got %0d exp 0", bus16.score); end
    tests++; if ({bus16.sweep_done, bus16.level_clear, bus16.busy} !== 3'b000) begin failed++; $display("FAIL reset_flags got %b exp 000", {bus16.sweep_done, bus16.level_clear, bus16.busy}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_static_sweep();
    bus16.tilemap_dots = pattern(60);
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    tests++; if (bus16.busy !== 1'b1) begin failed++; $display("FAIL init_busy got %b exp 1", bus16.busy); end
    tick_n(95);
    tests++; if (bus16.sweep_done !== 1'b0) begin failed++; $display("FAIL early_done got %b exp 0", bus16.sweep_done); end
    tick();
    tests++; if (bus16.sweep_done !== 1'b1) begin failed++; $display("FAIL first_done got %b exp 1", bus16.sweep_done); end
    tests++; if (bus16.dots_remaining !== 10'd60) begin failed++; $display("FAIL first_dots got %0d exp 60", bus16.dots_remaining); end
    tests++; if (bus16.dots_valid !== 1'b1) begin failed++; $display("FAIL first_valid got %b exp 1", bus16.dots_valid); end
    tests++; if (bus16.score !== 16'd0) begin failed++; $display("FAIL first_score got %0d exp 0", bus16.score); end
    tick();
    tests++; if (bus16.sweep_done !== 1'b0) begin failed++; $display("FAIL done_pulse_width got %b exp 0", bus16.sweep_done); end
    tick_n(95);
    tests++; if (bus16.sweep_done !== 1'b1 || bus16.dots_remaining !== 10'd60 || bus16.score !== 16'd0) begin
      failed++; $display("FAIL second_sweep got done=%b dots=%0d score=%0d exp 1/60/0", bus16.sweep_done, bus16.dots_remaining, bus16.score); end
  endtask

  task automatic test_score();
    bus16.tilemap_dots = pattern(57);
    tick_n(96);
    tests++; if (bus16.sweep_done !== 1'b1 || bus16.dots_remaining !== 10'd57) begin failed++; $display("FAIL drop3_dots got done=%b dots=%0d exp 1/57", bus16.sweep_done, bus16.dots_remaining); end
    tests++; if (bus16.score !== 16'd30) begin failed++; $display("FAIL drop3_score got %0d exp 30", bus16.score); end
    bus16.tilemap_dots = pattern(56);
    tick_n(96);
    tests++; if (bus16.dots_remaining !== 10'd56 || bus16.score !== 16'd40) begin failed++; $display("FAIL drop1 got dots=%0d score=%0d exp 56/40", bus16.dots_remaining, bus16.score); end
  endtask

  task automatic test_restart_mid_sweep();
    int early;
    early = 0;
    tick_n(30);
    bus16.tilemap_dots = pattern(54);
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    tests++; if (bus16.dots_valid !== 1'b0 || bus16.busy !== 1'b1 || bus16.dots_remaining !== 10'd56) begin
      failed++; $display("FAIL restart_state got valid=%b busy=%b dots=%0d exp 0/1/56", bus16.dots_valid, bus16.busy, bus16.dots_remaining); end
    for (int i = 0; i < 95; i++) begin
      tick();
      if (bus16.sweep_done === 1'b1) early++;
    end
    tests++; if (early !== 0) begin failed++; $display("FAIL restart_partial_done got %0d pulses exp 0", early); end
    tick();
    tests++; if (bus16.sweep_done !== 1'b1 || bus16.dots_remaining !== 10'd54 || bus16.dots_valid !== 1'b1) begin
      failed++; $display("FAIL restart_sweep got done=%b dots=%0d valid=%b exp 1/54/1", bus16.sweep_done, bus16.dots_remaining, bus16.dots_valid); end
    tests++; if (bus16.score !== 16'd40) begin failed++; $display("FAIL restart_score got %0d exp 40", bus16.score); end
  endtask

  task automatic test_level_clear();
    int pulses;
    pulses = 0;
    bus16.tilemap_dots = '0;
    tick_n(96);
    tests++; if (bus16.dots_remaining !== 10'd0 || bus16.level_clear !== 1'b1 || bus16.busy !== 1'b0) begin
      failed++; $display("FAIL clear_state got dots=%0d lvl=%b busy=%b exp 0/1/0", bus16.dots_remaining, bus16.level_clear, bus16.busy); end
    tests++; if (bus16.score !== 16'd580) begin failed++; $display("FAIL clear_score got %0d exp 580", bus16.score); end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus16.sweep_done === 1'b1 || bus16.level_clear !== 1'b1) pulses++;
    end
    tests++; if (pulses !== 0) begin failed++; $display("FAIL cleared_hold got %0d bad cycles exp 0", pulses); end
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    tests++; if (bus16.level_clear !== 1'b0 || bus16.busy !== 1'b1 || bus16.score !== 16'd580) begin
      failed++; $display("FAIL clear_restart got lvl=%b busy=%b score=%0d exp 0/1/580", bus16.level_clear, bus16.busy, bus16.score); end
  endtask

  task automatic test_empty_map();
    bus16.tilemap_dots = '0;
    bus16.start = 1'b1;
    bus16.score_clear = 1'b1;
    tick();
    bus16.start = 1'b0;
    bus16.score_clear = 1'b0;
    tests++; if (bus16.score !== 16'd0 || bus16.busy !== 1'b1) begin failed++; $display("FAIL start_and_clear got score=%0d busy=%b exp 0/1", bus16.score, bus16.busy); end
    tick_n(95);
    tests++; if (bus16.sweep_done !== 1'b0 || bus16.level_clear !== 1'b0) begin failed++; $display("FAIL empty_early got done=%b lvl=%b exp 0/0", bus16.sweep_done, bus16.level_clear); end
    tick();
    tests++; if (bus16.sweep_done !== 1'b1 || bus16.level_clear !== 1'b1 || bus16.dots_remaining !== 10'd0 || bus16.dots_valid !== 1'b1) begin
      failed++; $display("FAIL empty_sweep got done=%b lvl=%b dots=%0d valid=%b exp 1/1/0/1", bus16.sweep_done, bus16.level_clear, bus16.dots_remaining, bus16.dots_valid); end
    tests++; if (bus16.score !== 16'd0 || bus16.busy !== 1'b0) begin failed++; $display("FAIL empty_score got score=%0d busy=%b exp 0/0", bus16.score, bus16.busy); end
  endtask

  task automatic test_reset_mid_sweep();
    int bad;
    bad = 0;
    bus16.tilemap_dots = pattern(60);
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    tick_n(96);
    bus16.tilemap_dots = pattern(59);
    tick_n(96);
    tests++; if (bus16.dots_remaining !== 10'd59 || bus16.score !== 16'd10) begin failed++; $display("FAIL pre_reset got dots=%0d score=%0d exp 59/10", bus16.dots_remaining, bus16.score); end
    tick_n(40);
    #2 reset = 1'b0;
    #1;
    tests++; if (bus16.dots_remaining !== 10'd0 || bus16.score !== 16'd0 || bus16.dots_valid !== 1'b0) begin
      failed++; $display("FAIL async_reset got dots=%0d score=%0d valid=%b exp 0/0/0", bus16.dots_remaining, bus16.score, bus16.dots_valid); end
    tests++; if ({bus16.sweep_done, bus16.level_clear, bus16.busy} !== 3'b000) begin failed++; $display("FAIL async_reset_flags got %b exp 000", {bus16.sweep_done, bus16.level_clear, bus16.busy}); end
    #2 reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus16.sweep_done !== 1'b0 || bus16.busy !== 1'b0 || bus16.dots_valid !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin failed++; $display("FAIL idle_after_reset got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_saturation();
    bus8.tilemap_dots = pattern(60);
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick_n(96);
    tests++; if (bus8.dots_remaining !== 10'd60 || bus8.score !== 8'd0) begin failed++; $display("FAIL sat_init got dots=%0d score=%0d exp 60/0", bus8.dots_remaining, bus8.score); end
    bus8.tilemap_dots = pattern(35);
    tick_n(96);
    tests++; if (bus8.dots_remaining !== 10'd35 || bus8.score !== 8'd250) begin failed++; $display("FAIL sat_250 got dots=%0d score=%0d exp 35/250", bus8.dots_remaining, bus8.score); end
    bus8.tilemap_dots = pattern(33);
    tick_n(96);
    tests++; if (bus8.dots_remaining !== 10'd33 || bus8.score !== 8'd255) begin failed++; $display("FAIL sat_255 got dots=%0d score=%0d exp 33/255", bus8.dots_remaining, bus8.score); end
    bus8.tilemap_dots = pattern(32);
    tick_n(95);
    bus8.score_clear = 1'b1;
    tick();
    bus8.score_clear = 1'b0;
    tests++; if (bus8.sweep_done !== 1'b1 || bus8.dots_remaining !== 10'd32 || bus8.score !== 8'd0) begin
      failed++; $display("FAIL clear_beats_add got done=%b dots=%0d score=%0d exp 1/32/0", bus8.sweep_done, bus8.dots_remaining, bus8.score); end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b0;
    bus16.tilemap_dots = '0;
    bus16.start = 1'b0;
    bus16.score_clear = 1'b0;
    bus8.tilemap_dots = '0;
    bus8.start = 1'b0;
    bus8.score_clear = 1'b0;
    test_reset();
    test_static_sweep();
    test_score();
    test_restart_mid_sweep();
    test_level_clear();
    test_empty_map();
    test_reset_mid_sweep();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/dot_scoreboard.md
Name: dot_scoreboard

Overview:
- Reader/consumer of the shared dot bitmap `tilemap_dots`, which the player controller writes by clearing eaten dots.
- Continuously sweeps the bitmap in fixed-width chunks and maintains the count of remaining dots.
- Converts each sweep-to-sweep decrease into score and flags level clear when no dots remain.
- Sits beside the player controller and feeds the HUD/renderer and the game-state FSM.

Parameters:
ROWS, 24, tile rows (equals `tile_row_num)
COLS, 32, tile columns (equals `tile_col_num)
SCAN_W, 8, bitmap bits examined per clock; must divide ROWS*COLS
POINTS_PER_DOT, 10, score added per eaten dot
SCORE_W, 16, score width
(derived) NT = ROWS*COLS; NCHUNK = NT/SCAN_W; CNT_W = $clog2(NT+1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tilemap_dots  input  NT  dot bitmap; bit r*COLS+c set = dot present
start  input  1  one-cycle pulse: begin/restart level counting
score_clear  input  1  synchronous score zero
dots_remaining  output  CNT_W  dot count from the last completed sweep
dots_valid  output  1  dots_remaining holds a completed sweep
score  output  SCORE_W  accumulated score, saturating
sweep_done  output  1  one-cycle pulse per completed sweep
level_clear  output  1  high while in CLEARED
busy  output  1  high in INIT or RUN

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE, idx=0, acc=0.
  - dots_remaining=0, dots_valid=0, score=0, sweep_done=0, level_clear=0.
- States: IDLE, INIT, RUN, CLEARED.
- Scan step, every cycle in INIT or RUN:
  - pop = popcount(tilemap_dots[idx*SCAN_W +: SCAN_W]).
  - If idx<NCHUNK-1: acc<=acc+pop, idx<=idx+1.
  - If idx==NCHUNK-1: total=acc+pop; acc<=0; idx<=0; sweep end processing (below) happens in the same edge.
  - One sweep takes exactly NCHUNK cycles. Results are visible the cycle after the last chunk.
- The bitmap is not snapshotted. Each chunk is counted with its value at its own sample cycle.
- IDLE: outputs hold. On start: idx=0, acc=0, dots_valid<=0, go to INIT.
- INIT sweep end:
  - dots_remaining<=total, dots_valid<=1, sweep_done<=1, no score change.
  - If total==0: level_clear<=1, go to CLEARED. Else go to RUN.
- RUN sweep end:
  - If total<dots_remaining: score<=min(score+(dots_remaining-total)*POINTS_PER_DOT, 2^SCORE_W-1). The multiply and add are done at width SCORE_W+CNT_W+1 before saturating.
  - If total>=dots_remaining (dots restored or unchanged): no score change.
  - dots_remaining<=total, sweep_done<=1.
  - If total==0: level_clear<=1, go to CLEARED. Else stay in RUN.
- CLEARED: no scanning; outputs hold.
- start in any state (INIT/RUN/CLEARED):
  - Aborts the current sweep: idx=0, acc=0, level_clear<=0, dots_valid<=0, go to INIT.
  - A partial sweep's result is discarded.
  - score is kept.
- score_clear: score<=0 next edge. It has priority over a simultaneous sweep-end add (the add is dropped). It has no effect on state or count.
- start together with score_clear: both take effect.
- sweep_done is high only in the cycle following a sweep's last chunk; otherwise 0.
- busy = (state==INIT || state==RUN), combinational from state.

Test Plan:
1. Reset then start with 60 dots set, bitmap static → after 96 cycles: sweep_done pulse, dots_remaining=60, dots_valid=1, score=0, state RUN; each further sweep pulses every 96 cycles with score unchanged.
2. In RUN with 60 dots, clear 3 bits between sweeps → next sweep end: dots_remaining=57, score=30; clear 1 more → 56, score=40.
3. Clear all remaining dots → at that sweep end: dots_remaining=0, level_clear=1, busy=0; no further sweep_done pulses; start → level_clear=0, INIT, score retained.
4. Start with an all-zero bitmap → after 96 cycles: dots_remaining=0, level_clear=1, score=0.
5. SCORE_W=8, score=250, drop 2 dots → score saturates to 255; score_clear asserted on the sweep-end edge with a 1-dot drop → score=0.
6. Assert reset mid-sweep (idx=40) → outputs immediately zero, IDLE, no sweep_done; pulse start mid-RUN sweep → partial count discarded and a fresh INIT sweep completes 96 cycles later without score change.
